// File: rtl/serdes_pkg.sv
// Shared definitions for the framed SERDES link (transmitter and receiver).
// Contents:
//   tx_state_t  - transmitter FSM state encoding
//   DATA_W_DEF  - default data bits per frame
//   LINE_IDLE / START_BIT / STOP_BIT - line levels
//   frame_len() - line cycles per frame, excluding any forced idle gap
package serdes_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam logic        LINE_IDLE  = 1'b1;
    localparam logic        START_BIT  = 1'b0;
    localparam logic        STOP_BIT   = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StGap
    } tx_state_t;

    // Start + data + optional parity + stop.
    function automatic int unsigned frame_len(input int unsigned data_w, input bit parity_en);
        return 32'(2 + data_w) + {31'd0, parity_en};
    endfunction

endpackage

// File: rtl/serdes_hold_reg.sv
// One-entry valid/ready holding register.
// Ports:
//   clk, nreset  - clock, asynchronous active-low reset
//   para_in      - word offered by the producer
//   in_valid     - para_in is valid this cycle
//   in_ready     - register empty (registered, no path from in_valid)
//   data_out     - held word
//   full         - a word is held
//   drain        - consumer takes the held word this cycle (only meaningful while full)
module serdes_hold_reg
    import serdes_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic [DATA_W-1:0] para_in,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] data_out,
    output logic              full,
    input  logic              drain
);

    logic              r_full;
    logic [DATA_W-1:0] r_data;

    // Drain and accept never coincide: drain needs full, accept needs empty.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else begin
            if (drain) begin
                r_full <= 1'b0;
            end
            if (in_valid && !r_full) begin
                r_full <= 1'b1;
                r_data <= para_in;
            end
        end
    end

    assign in_ready = !r_full;
    assign data_out = r_data;
    assign full     = r_full;

endmodule

// File: rtl/serial_frame_tx.sv
// Framed serial transmitter: start bit, DATA_W data bits LSB-first, optional even
// parity bit, stop bit, then IDLE_GAP forced idle cycles. One line bit per clk.
// Ports:
//   clk, nreset - clock, asynchronous active-low reset
//   para_in     - word to transmit
//   in_valid    - para_in valid
//   in_ready    - holding register empty; accept on in_valid && in_ready
//   serial_out  - registered serial line, idle high
//   busy        - registered; high while a frame or gap is on the line
module serial_frame_tx
    import serdes_pkg::*;
#(
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter bit          PARITY_EN = 1'b1,
    parameter int unsigned IDLE_GAP  = 0
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic [DATA_W-1:0] para_in,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              serial_out,
    output logic              busy
);

    localparam int unsigned    CNT_W     = 4;
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    // Unused (and meaningless) when IDLE_GAP is 0: the gap state is never entered.
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(IDLE_GAP - 1);

    logic [DATA_W-1:0] w_hold_data;
    logic              w_hold_full;
    logic              w_drain;

    tx_state_t         r_state,  w_state_next;
    logic [DATA_W-1:0] r_shift,  w_shift_next;
    logic [CNT_W-1:0]  r_cnt,    w_cnt_next;
    logic              r_parity, w_parity_next;
    logic              r_serial, w_serial_next;
    logic              r_busy;
    logic              w_try_load;

    serdes_hold_reg #(
        .DATA_W (DATA_W)
    ) u_hold (
        .clk      (clk),
        .nreset   (nreset),
        .para_in  (para_in),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .data_out (w_hold_data),
        .full     (w_hold_full),
        .drain    (w_drain)
    );

    // The line bit is computed for the state being entered so that serial_out
    // changes on the same edge as the state register.
    always_comb begin
        w_state_next  = r_state;
        w_shift_next  = r_shift;
        w_cnt_next    = r_cnt;
        w_parity_next = r_parity;
        w_serial_next = LINE_IDLE;
        w_drain       = 1'b0;
        w_try_load    = 1'b0;

        unique case (r_state)
            StIdle: begin
                w_try_load = 1'b1;
            end
            StStart: begin
                w_state_next  = StData;
                w_cnt_next    = '0;
                w_serial_next = r_shift[0];
                w_parity_next = r_parity ^ r_shift[0];
                w_shift_next  = r_shift >> 1;
            end
            StData: begin
                if (r_cnt == DATA_LAST) begin
                    if (PARITY_EN) begin
                        w_state_next  = StParity;
                        w_serial_next = r_parity;
                    end else begin
                        w_state_next  = StStop;
                        w_serial_next = STOP_BIT;
                    end
                end else begin
                    w_cnt_next    = r_cnt + 4'd1;
                    w_serial_next = r_shift[0];
                    w_parity_next = r_parity ^ r_shift[0];
                    w_shift_next  = r_shift >> 1;
                end
            end
            StParity: begin
                w_state_next  = StStop;
                w_serial_next = STOP_BIT;
            end
            StStop: begin
                if (IDLE_GAP > 0) begin
                    w_state_next = StGap;
                    w_cnt_next   = '0;
                end else begin
                    w_try_load = 1'b1;
                end
            end
            StGap: begin
                if (r_cnt == GAP_LAST) begin
                    w_try_load = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + 4'd1;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase

        // Common end-of-frame decision: start the held word or fall idle.
        if (w_try_load) begin
            if (w_hold_full) begin
                w_state_next  = StStart;
                w_shift_next  = w_hold_data;
                w_parity_next = 1'b0;
                w_serial_next = START_BIT;
                w_drain       = 1'b1;
            end else begin
                w_state_next  = StIdle;
                w_serial_next = LINE_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state  <= StIdle;
            r_shift  <= '0;
            r_cnt    <= '0;
            r_parity <= 1'b0;
            r_serial <= LINE_IDLE;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_shift  <= w_shift_next;
            r_cnt    <= w_cnt_next;
            r_parity <= w_parity_next;
            r_serial <= w_serial_next;
            r_busy   <= (w_state_next != StIdle);
        end
    end

    assign serial_out = r_serial;
    assign busy       = r_busy;

endmodule

// File: doc/serial_frame_tx.md
Name: serial_frame_tx

Overview:
Framed serial transmitter for the SERDES link. It accepts parallel words over a valid/ready handshake and buffers one word in a holding register. Each word goes out on a single line, one bit per clk: a start bit, the data LSB-first, an optional even-parity bit, then a stop bit. This is the transmitting end that feeds the link's framed receiver, and it replaces the raw, unframed serial path when frame delimiting is needed.

Parameters:
DATA_W, 8, data bits per frame (range 1..16)
PARITY_EN, 1, 1 = append even-parity bit; 0 = no parity bit
IDLE_GAP, 0, minimum idle-high cycles forced between a stop bit and the next start bit (range 0..15)

Ports:
clk  input  1  rising-edge clock; one line bit per cycle
nreset  input  1  asynchronous active-low reset
para_in  input  DATA_W  word to transmit
in_valid  input  1  para_in is valid this cycle
in_ready  output  1  holding register empty; word accepted when in_valid && in_ready at a clk edge
serial_out  output  1  serial line, registered; idle level is 1
busy  output  1  1 while a frame (START through STOP, and any GAP) is on the line

Behaviour:
- Reset (nreset low, async): serial_out=1, in_ready=1, busy=0, FSM=IDLE, holding register empty, bit counter=0. Asserting reset mid-frame aborts the frame: the line goes high immediately and any held word is discarded.
- Holding register: in_ready = !hold_full, registered, with no combinational path from in_valid. An accept sets hold_full and captures para_in.
- FSM states: IDLE, START, DATA, PARITY, STOP, GAP.
- IDLE: serial_out=1, busy=0. If hold_full: load the shift register from the holding register, clear hold_full, go to START.
- START: serial_out=0 for 1 cycle, then DATA.
- DATA: shift out DATA_W bits LSB-first, 1 cycle each. The counter runs 0..DATA_W-1, then goes to PARITY if PARITY_EN, else STOP.
- PARITY: serial_out = XOR of all data bits (even parity over data plus parity bit), 1 cycle.
- STOP: serial_out=1 for 1 cycle. Next state:
  - IDLE_GAP>0: go to GAP.
  - hold_full: reload, go to START (back-to-back frames).
  - otherwise: go to IDLE.
- GAP: serial_out=1 for IDLE_GAP cycles, then the same reload/IDLE decision as STOP.
- Frame length = 2 + DATA_W + PARITY_EN cycles (11 at defaults).
- Latency: accept at edge N; hold_full visible after N. Load at edge N+1; the start bit is visible from edge N+1 to edge N+2.
- Simultaneous drain and accept in one cycle: impossible, because in_ready was low. in_ready rises the cycle after the drain.
- Word accepted while a frame is in progress: it is held and sent after STOP/GAP. At most one word is held.
- busy=1 in all states except IDLE and is registered alongside serial_out. Its reset value is 0.
- in_valid held while in_ready is low: no capture, and para_in is ignored.

Decomposition:
- Shared package serdes_pkg:
  - FSM state enum (tx_state_t).
  - Default localparams DATA_W_DEF=8, LINE_IDLE=1'b1, START_BIT=1'b0, STOP_BIT=1'b1.
  - Function frame_len(DATA_W, PARITY_EN), also reused by the matching framed receiver.
- One sub-module is natural: serdes_hold_reg, a one-entry valid/ready holding register (para_in, in_valid, in_ready, data_out, full, drain). The matching receiver-side output buffer reuses it.
- The FSM, shift register and parity accumulator stay in serial_frame_tx.

Test Plan:
- Reset values: hold nreset=0 with in_valid=1 and para_in=8'hFF -> serial_out=1, in_ready=1, busy=0 throughout; no frame starts after release until a fresh accept.
- Single frame 8'hA5, defaults: accept at edge N -> the line from edge N+1 reads 0, 1,0,1,0,0,1,0,1, 0 (parity), 1 (stop), then idle 1; busy high for exactly 11 cycles.
- Back-to-back 8'h01 then 8'hFF, in_valid held, IDLE_GAP=0:
  - the second word is accepted during frame 1, then in_ready stays low;
  - the stop bit of frame 1 is immediately followed by the start bit of frame 2, with no idle cycle;
  - frame 2 is 0, eight 1s, parity 0, stop 1.
- PARITY_EN=0, DATA_W=8, word 8'h80 -> 10-cycle frame 0, 0000000, 1, 1 (stop); there is no parity cycle.
- IDLE_GAP=2, two queued words 8'h00 -> exactly 2 idle-high cycles between the stop and the next start; frame 1 parity bit = 0.
- Async reset during DATA bit 3 of 8'h3C with a second word held -> serial_out=1 within the same cycle, busy=0, in_ready=1; the held word is never transmitted.
